// File: rtl/hist_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : hist_frame_ctrl
//  Purpose  : Frame-level sequencer for the histogram-equalisation datapath.
//             Counts accepted pixels against the active frame size and flags
//             end-of-frame. Flips the ping-pong histogram bank there, then
//             runs a read-and-clear scan of the retired bank. The scan ends
//             with a LUT bank swap. The pixel stream is stalled only when the
//             next frame would end before the scan is done.
//  Ports    : clk, rst                async active-high reset
//             i_control_in_data/valid {width[35:20], height[19:4], 4'h0}
//             i_pix_valid/o_pix_ready pixel handshake
//             o_hist_bank             bank currently accumulating
//             o_frame_eop             pulse, cycle after the last pixel
//             o_scan_*                scan strobe, address, bank, first/last
//             o_lut_swap/o_lut_bank   LUT completion pulse and active bank
//             o_busy                  scan/swap in progress
//             o_cfg_err               rejected configuration pulse
//             o_control_out_data/valid active frame size and publish pulse
//  Revision : 1.0  initial release
// ============================================================================
module hist_frame_ctrl #(
  parameter int W_DEF = 1920,
  parameter int H_DEF = 1080,
  parameter int NBINS = 256,
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [35:0] i_control_in_data,
  input  logic        i_control_in_valid,
  input  logic        i_pix_valid,
  output logic        o_pix_ready,
  output logic        o_hist_bank,
  output logic        o_frame_eop,
  output logic        o_scan_en,
  output logic [7:0]  o_scan_addr,
  output logic        o_scan_bank,
  output logic        o_scan_first,
  output logic        o_scan_last,
  output logic        o_lut_swap,
  output logic        o_lut_bank,
  output logic        o_busy,
  output logic        o_cfg_err,
  output logic [35:0] o_control_out_data,
  output logic        o_control_out_valid
);

  localparam logic [7:0] c_SCAN_LAST = 8'(NBINS - 1);

  typedef enum logic [1:0] {
    ST_ACC  = 2'd0,
    ST_SCAN = 2'd1,
    ST_SWAP = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_pix_cnt;
  logic [15:0]      r_width;
  logic [15:0]      r_height;
  logic [15:0]      r_pend_w;
  logic [15:0]      r_pend_h;
  logic             r_pend_valid;
  logic             r_pub_init;
  logic             r_hist_bank;
  logic             r_frame_eop;
  logic             r_scan_en;
  logic [7:0]       r_scan_addr;
  logic             r_scan_bank;
  logic             r_scan_first;
  logic             r_scan_last;
  logic             r_lut_swap;
  logic             r_lut_bank;
  logic             r_cfg_err;
  logic             r_ctrl_valid;

  logic [CNT_W-1:0] w_total;
  logic             w_cnt_last;
  logic             w_busy;
  logic             w_pix_ready;
  logic             w_accept;
  logic             w_frame_end;
  logic [15:0]      w_cfg_w;
  logic [15:0]      w_cfg_h;
  logic             w_cfg_ok;
  logic             w_cfg_bad;
  logic             w_cfg_now;
  logic             w_unused;

  assign w_total     = CNT_W'(r_width) * CNT_W'(r_height);
  assign w_cnt_last  = (r_pix_cnt == (w_total - CNT_W'(1)));
  assign w_busy      = (r_state != ST_ACC);
  // Hold back the last pixel of a frame until the previous scan/swap retires,
  // so every frame gets its own eop and scan.
  assign w_pix_ready = ~rst & ~(w_busy & w_cnt_last);
  assign w_accept    = i_pix_valid & w_pix_ready;
  assign w_frame_end = w_accept & w_cnt_last;

  assign w_cfg_w   = i_control_in_data[35:20];
  assign w_cfg_h   = i_control_in_data[19:4];
  assign w_cfg_ok  = i_control_in_valid & (w_cfg_w != 16'd0) & (w_cfg_h != 16'd0);
  assign w_cfg_bad = i_control_in_valid & ~w_cfg_ok;
  // Between frames with nothing arriving, a new size can go live at once.
  assign w_cfg_now = w_cfg_ok & (r_pix_cnt == '0) & ~w_accept;
  assign w_unused  = ^i_control_in_data[3:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_ACC;
      r_pix_cnt    <= '0;
      r_width      <= 16'(W_DEF);
      r_height     <= 16'(H_DEF);
      r_pend_w     <= 16'd0;
      r_pend_h     <= 16'd0;
      r_pend_valid <= 1'b0;
      r_pub_init   <= 1'b1;
      r_hist_bank  <= 1'b0;
      r_frame_eop  <= 1'b0;
      r_scan_en    <= 1'b0;
      r_scan_addr  <= 8'd0;
      r_scan_bank  <= 1'b0;
      r_scan_first <= 1'b0;
      r_scan_last  <= 1'b0;
      r_lut_swap   <= 1'b0;
      r_lut_bank   <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_ctrl_valid <= 1'b0;
    end else begin
      r_frame_eop  <= 1'b0;
      r_lut_swap   <= 1'b0;
      r_cfg_err    <= w_cfg_bad;
      // The active size is published once after reset release.
      r_ctrl_valid <= r_pub_init;
      r_pub_init   <= 1'b0;

      if (w_accept) begin
        r_pix_cnt <= w_cnt_last ? '0 : r_pix_cnt + CNT_W'(1);
      end

      // A strobe coinciding with the last pixel beats any older pending size.
      if (w_frame_end) begin
        if (w_cfg_ok) begin
          r_width      <= w_cfg_w;
          r_height     <= w_cfg_h;
          r_ctrl_valid <= 1'b1;
          r_pend_valid <= 1'b0;
        end else if (r_pend_valid) begin
          r_width      <= r_pend_w;
          r_height     <= r_pend_h;
          r_ctrl_valid <= 1'b1;
          r_pend_valid <= 1'b0;
        end
      end else if (w_cfg_now) begin
        r_width      <= w_cfg_w;
        r_height     <= w_cfg_h;
        r_ctrl_valid <= 1'b1;
        r_pend_valid <= 1'b0;
      end else if (w_cfg_ok) begin
        r_pend_w     <= w_cfg_w;
        r_pend_h     <= w_cfg_h;
        r_pend_valid <= 1'b1;
      end

      case (r_state)
        ST_ACC: begin
          if (w_frame_end) begin
            r_state      <= ST_SCAN;
            r_frame_eop  <= 1'b1;
            r_hist_bank  <= ~r_hist_bank;
            r_scan_bank  <= r_hist_bank;
            r_scan_en    <= 1'b1;
            r_scan_addr  <= 8'd0;
            r_scan_first <= 1'b1;
            r_scan_last  <= (c_SCAN_LAST == 8'd0);
          end
        end
        ST_SCAN: begin
          if (r_scan_addr == c_SCAN_LAST) begin
            r_state      <= ST_SWAP;
            r_scan_en    <= 1'b0;
            r_scan_addr  <= 8'd0;
            r_scan_bank  <= 1'b0;
            r_scan_first <= 1'b0;
            r_scan_last  <= 1'b0;
            r_lut_swap   <= 1'b1;
            r_lut_bank   <= ~r_lut_bank;
          end else begin
            r_scan_addr  <= r_scan_addr + 8'd1;
            r_scan_first <= 1'b0;
            r_scan_last  <= ((r_scan_addr + 8'd1) == c_SCAN_LAST);
          end
        end
        ST_SWAP: begin
          r_state <= ST_ACC;
        end
        default: begin
          r_state <= ST_ACC;
        end
      endcase
    end
  end

  assign o_pix_ready         = w_pix_ready;
  assign o_hist_bank         = r_hist_bank;
  assign o_frame_eop         = r_frame_eop;
  assign o_scan_en           = r_scan_en;
  assign o_scan_addr         = r_scan_addr;
  assign o_scan_bank         = r_scan_bank;
  assign o_scan_first        = r_scan_first;
  assign o_scan_last         = r_scan_last;
  assign o_lut_swap          = r_lut_swap;
  assign o_lut_bank          = r_lut_bank;
  assign o_busy              = w_busy;
  assign o_cfg_err           = r_cfg_err;
  assign o_control_out_data  = {r_width, r_height, 4'h0};
  assign o_control_out_valid = r_ctrl_valid;

endmodule
`default_nettype wire
